// File: rtl/button_debounce_1ms_pkg.sv
// Shared state encoding, default timing constants and width helper for the
// button debounce block and its prescaler.
`timescale 1ns/1ps
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    CONFIRM_P = 2'd1,
    PRESSED   = 2'd2,
    CONFIRM_R = 2'd3
  } btnState_t;

  localparam int unsigned TICK_DIV_DEF  = 12000;
  localparam int unsigned STABLE_MS_DEF = 5;
  localparam int unsigned LONG_MS_DEF   = 1000;

  // Bits needed to hold values 0..maxVal, never less than one.
  function automatic int unsigned cntWidth(input int unsigned maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/button_debounce_1ms_if.sv
// Button-side signal bundle: raw level in, debounced level and events out.
`timescale 1ns/1ps
interface button_debounce_1ms_if;
  logic       btn;
  logic       level;
  logic       press;
  logic       rel;
  logic       longEv;
  logic [7:0] cnt;

  modport master (output btn, input level, press, rel, longEv, cnt);
  modport slave  (input btn, output level, press, rel, longEv, cnt);
endinterface

// File: rtl/button_debounce_1ms_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, first tick DIV
// cycles after reset is released. Shared with the LED blink logic.
`timescale 1ns/1ps
module tick_gen
  import button_pkg::*;
#(
  parameter int unsigned DIV = TICK_DIV_DEF
) (
  input  logic iCLK,
  input  logic iRST,
  output logic oTICK
);

  localparam int unsigned W = cntWidth(DIV - 1);

  logic [W-1:0] count;

  assign oTICK = (count == W'(DIV - 1));

  always_ff @(posedge iCLK) begin
    if (iRST)       count <= '0;
    else if (oTICK) count <= '0;
    else            count <= count + 1'b1;
  end

endmodule

// File: rtl/button_debounce_1ms.sv
// Debounces a raw push button on a 1 ms tick grid and reports press, release
// and long-press events plus a wrapping count of accepted presses.
`timescale 1ns/1ps
module button_debounce_1ms
  import button_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned STABLE_MS = STABLE_MS_DEF,
  parameter int unsigned LONG_MS   = LONG_MS_DEF
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iBTN,
  output logic       oBTN,
  output logic       oPRESS,
  output logic       oRELEASE,
  output logic       oLONG,
  output logic [7:0] oCNT
);

  localparam int unsigned SW = cntWidth(STABLE_MS);
  localparam int unsigned HW = cntWidth(LONG_MS);

  logic          syncA;
  logic          s;
  logic          tick;
  btnState_t     state;
  logic [SW-1:0] stableCnt;
  logic [HW-1:0] holdCnt;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      syncA <= 1'b0;
      s     <= 1'b0;
    end else begin
      syncA <= iBTN;
      s     <= syncA;
    end
  end

  tick_gen #(.DIV(TICK_DIV)) uTick (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .oTICK (tick)
  );

  // The first agreeing tick is counted on leaving a stable state, so the
  // confirm states accept on reaching STABLE_MS-1 before their increment.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= RELEASED;
      stableCnt <= '0;
      holdCnt   <= '0;
      oBTN      <= 1'b0;
      oPRESS    <= 1'b0;
      oRELEASE  <= 1'b0;
      oLONG     <= 1'b0;
      oCNT      <= '0;
    end else begin
      oPRESS   <= 1'b0;
      oRELEASE <= 1'b0;
      oLONG    <= 1'b0;
      if (tick) begin
        case (state)
          RELEASED: begin
            if (s) begin
              state     <= CONFIRM_P;
              stableCnt <= SW'(1);
            end
          end
          CONFIRM_P: begin
            if (s) begin
              if (stableCnt == SW'(STABLE_MS - 1)) begin
                state     <= PRESSED;
                stableCnt <= '0;
                holdCnt   <= '0;
                oBTN      <= 1'b1;
                oPRESS    <= 1'b1;
                oCNT      <= oCNT + 8'd1;
              end else begin
                stableCnt <= stableCnt + 1'b1;
              end
            end else begin
              state     <= RELEASED;
              stableCnt <= '0;
            end
          end
          PRESSED: begin
            if (s) begin
              if (holdCnt != HW'(LONG_MS)) begin
                holdCnt <= holdCnt + 1'b1;
                if (holdCnt == HW'(LONG_MS - 1)) oLONG <= 1'b1;
              end
            end else begin
              state     <= CONFIRM_R;
              stableCnt <= SW'(1);
            end
          end
          CONFIRM_R: begin
            if (!s) begin
              if (stableCnt == SW'(STABLE_MS - 1)) begin
                state     <= RELEASED;
                stableCnt <= '0;
                oBTN      <= 1'b0;
                oRELEASE  <= 1'b1;
              end else begin
                stableCnt <= stableCnt + 1'b1;
              end
            end else begin
              state     <= PRESSED;
              stableCnt <= '0;
            end
          end
          default: begin
            state     <= RELEASED;
            stableCnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_debounce_1ms.sv
// Randomized bench for button_debounce_1ms against a run-length reference model.
`timescale 1ns/1ps
module tb_button_debounce_1ms;

  localparam int unsigned DIV = 12;
  localparam int unsigned STB = 5;
  localparam int unsigned LNG = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_debounce_1ms_if bif();

  always #41.67 clk = ~clk;

  button_debounce_1ms #(
    .TICK_DIV  (DIV),
    .STABLE_MS (STB),
    .LONG_MS   (LNG)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iBTN     (bif.btn),
    .oBTN     (bif.level),
    .oPRESS   (bif.press),
    .oRELEASE (bif.rel),
    .oLONG    (bif.longEv),
    .oCNT     (bif.cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: the accepted level flips once the synchronized button has
  // disagreed with it on STB consecutive ticks; hold time counts agreeing ticks.
  int mDiv = 0, mRun = 0, mHold = 0, mCnt = 0;
  bit mS1 = 0, mS2 = 0, mLvl = 0, mPress = 0, mRel = 0, mLong = 0;

  always @(posedge clk) begin
    bit tk;
    bit sv;
    if (rst) begin
      mDiv = 0; mRun = 0; mHold = 0; mCnt = 0;
      mS1 = 0; mS2 = 0; mLvl = 0; mPress = 0; mRel = 0; mLong = 0;
    end else begin
      tk = (mDiv == DIV - 1);
      sv = mS2;
      mPress = 0; mRel = 0; mLong = 0;
      if (tk) begin
        if (sv != mLvl) begin
          mRun++;
          if (mRun == STB) begin
            mRun = 0;
            mLvl = sv;
            if (sv) begin
              mPress = 1;
              mHold  = 0;
              mCnt   = (mCnt + 1) % 256;
            end else begin
              mRel = 1;
            end
          end
        end else begin
          if (mLvl && mRun == 0 && mHold < LNG) begin
            mHold++;
            if (mHold == LNG) mLong = 1;
          end
          mRun = 0;
        end
      end
      mS2 = mS1;
      mS1 = bif.btn;
      mDiv = tk ? 0 : mDiv + 1;
    end
  end

  longint cyc = 0, lastPress = 0, lastRel = 0, lastLong = 0;
  int pressN = 0, relN = 0, longN = 0;
  bit chkEn = 0;

  always @(negedge clk) begin
    cyc++;
    if (bif.press === 1'b1)  begin pressN++; lastPress = cyc; end
    if (bif.rel === 1'b1)    begin relN++;   lastRel   = cyc; end
    if (bif.longEv === 1'b1) begin longN++;  lastLong  = cyc; end
    if (chkEn)
      checkVal("outs",
               {20'd0, bif.level, bif.press, bif.rel, bif.longEv, bif.cnt},
               {20'd0, mLvl, mPress, mRel, mLong, 8'(mCnt)});
  end

  task automatic waitTicks(input int unsigned n);
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic waitPhase();
    repeat ($urandom_range(0, DIV - 1)) @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic bit inLatency(input longint d);
    return (d >= 4 * DIV) && (d <= 5 * DIV + 4);
  endfunction

  int p0, r0, l0;
  longint e0;

  initial begin
    bif.btn = 1'b0;
    @(negedge clk);
    doReset();
    chkEn = 1'b1;
    checkVal("rstLevel", bif.level, 0);
    checkVal("rstPulses", {bif.press, bif.rel, bif.longEv}, 0);
    checkVal("rstCnt", bif.cnt, 0);

    // glitch shorter than the qualification window
    waitPhase();
    p0 = pressN;
    bif.btn = 1'b1;
    waitTicks(3);
    bif.btn = 1'b0;
    waitTicks(8);
    checkVal("glitchPress", pressN - p0, 0);
    checkVal("glitchLevel", bif.level, 0);
    checkVal("glitchCnt", bif.cnt, 0);

    // clean press and release
    waitPhase();
    p0 = pressN;
    bif.btn = 1'b1;
    e0 = cyc;
    waitTicks(10);
    checkVal("cleanPress", pressN - p0, 1);
    checkVal("cleanLevel", bif.level, 1);
    checkVal("cleanCnt", bif.cnt, 1);
    checkVal("pressLatency", 32'(inLatency(lastPress - e0)), 1);
    r0 = relN;
    bif.btn = 1'b0;
    e0 = cyc;
    waitTicks(8);
    checkVal("cleanRelease", relN - r0, 1);
    checkVal("cleanRelLevel", bif.level, 0);
    checkVal("relLatency", 32'(inLatency(lastRel - e0)), 1);

    // bounce that settles high
    waitPhase();
    p0 = pressN;
    r0 = relN;
    bif.btn = 1'b1;
    repeat ($urandom_range(12, 18)) @(negedge clk);
    bif.btn = 1'b0;
    repeat ($urandom_range(12, 18)) @(negedge clk);
    bif.btn = 1'b1;
    waitTicks(10);
    checkVal("bouncePress", pressN - p0, 1);
    checkVal("bounceRelease", relN - r0, 0);
    bif.btn = 1'b0;
    waitTicks(8);

    // long hold
    waitPhase();
    p0 = pressN;
    l0 = longN;
    bif.btn = 1'b1;
    waitTicks(30);
    checkVal("longPress", pressN - p0, 1);
    checkVal("longCount", longN - l0, 1);
    checkVal("longDelay", 32'(lastLong - lastPress), LNG * DIV);
    r0 = relN;
    bif.btn = 1'b0;
    e0 = cyc;
    waitTicks(8);
    checkVal("longRelease", relN - r0, 1);
    checkVal("longRelLatency", 32'(inLatency(lastRel - e0)), 1);

    // random segments, checked cycle by cycle against the model
    for (int i = 0; i < 80; i++) begin
      bif.btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8 * DIV)) @(negedge clk);
    end
    bif.btn = 1'b0;
    waitTicks(8);
    checkVal("randomSettled", bif.level, 0);

    // counter wrap after 256 presses
    doReset();
    p0 = pressN;
    for (int i = 0; i < 256; i++) begin
      bif.btn = 1'b1;
      waitTicks(6);
      bif.btn = 1'b0;
      waitTicks(6);
    end
    checkVal("wrapPresses", pressN - p0, 256);
    checkVal("wrapCnt", bif.cnt, 0);

    // reset while pressed, button still held afterwards
    bif.btn = 1'b1;
    waitTicks(7);
    checkVal("midLevel", bif.level, 1);
    r0 = relN;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkVal("midRstLevel", bif.level, 0);
    checkVal("midRstRel", bif.rel, 0);
    checkVal("midRstCnt", bif.cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = pressN;
    waitTicks(7);
    checkVal("requalPress", pressN - p0, 1);
    checkVal("requalCnt", bif.cnt, 1);
    checkVal("requalLevel", bif.level, 1);
    checkVal("midNoRelease", relN - r0, 0);
    bif.btn = 1'b0;
    waitTicks(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce_1ms.md
BUTTON_DEBOUNCE_1MS -- requirements
Module: button_debounce_1ms

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 12000, giving clocks per 1 ms tick at the 12 MHz board clock.
REQ-002 The block SHALL have parameter STABLE_MS, default 5, giving the consecutive agreeing ticks needed to accept a level change.
REQ-003 The block SHALL have parameter LONG_MS, default 1000, giving the pressed ticks before a long-press event.
REQ-004 The block SHALL have port iCLK  input  1  system clock, 12 MHz.
REQ-005 The block SHALL have port iRST  input  1  reset; one clock, synchronous, active-high.
REQ-006 The block SHALL have port iBTN  input  1  raw asynchronous button level, 1 = pressed.
REQ-007 The block SHALL have port oBTN  output  1  debounced button level.
REQ-008 The block SHALL have port oPRESS  output  1  one-cycle pulse on accepted press.
REQ-009 The block SHALL have port oRELEASE  output  1  one-cycle pulse on accepted release.
REQ-010 The block SHALL have port oLONG  output  1  one-cycle pulse when a press has been held LONG_MS ticks.
REQ-011 The block SHALL have port oCNT  output  8  count of accepted presses.

Function
REQ-012 iBTN SHALL pass through a 2-flop synchronizer; the FSM uses only the synchronized value s.
REQ-013 The prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick for exactly one cycle when the count equals TICK_DIV-1.
REQ-014 The FSM SHALL have states RELEASED, CONFIRM_P, PRESSED and CONFIRM_R, and evaluate s only on tick cycles.
REQ-015 In RELEASED, a tick with s=1 SHALL go to CONFIRM_P with stable count 1; a tick with s=0 SHALL stay in RELEASED.
REQ-016 In CONFIRM_P, a tick with s=1 SHALL increment the stable count; at STABLE_MS it SHALL go to PRESSED, clear the hold counter and pulse oPRESS.
REQ-017 In CONFIRM_P, a tick with s=0 SHALL return to RELEASED with stable count 0 and no pulse.
REQ-018 In PRESSED, each tick with s=1 SHALL increment the hold counter; on reaching LONG_MS it SHALL pulse oLONG once, then saturate with no further oLONG that press.
REQ-019 In PRESSED, a tick with s=0 SHALL go to CONFIRM_R with stable count 1.
REQ-020 In CONFIRM_R, a tick with s=0 SHALL increment the stable count; at STABLE_MS it SHALL go to RELEASED and pulse oRELEASE.
REQ-021 In CONFIRM_R, a tick with s=1 SHALL return to PRESSED, keeping the hold counter and pulsing nothing.
REQ-022 In CONFIRM_R, the hold counter SHALL NOT advance.
REQ-023 oBTN SHALL be 1 in PRESSED and CONFIRM_R, and 0 in RELEASED and CONFIRM_P.
REQ-024 All outputs SHALL be registered, changing on the clock edge immediately after the deciding tick cycle.
REQ-025 oCNT SHALL increment on each oPRESS and wrap from 255 to 0.
REQ-026 oPRESS, oRELEASE and oLONG SHALL never be asserted in the same cycle.
REQ-027 When STABLE_MS equals LONG_MS, oLONG SHALL follow oPRESS by LONG_MS further ticks, never in the same cycle.

Reset
REQ-028 While iRST=1 at a clock edge, the block SHALL clear the synchronizer, prescaler, counters and oCNT, enter RELEASED, and drive every output to 0.
REQ-029 A reset mid-press SHALL discard the press; a button still held at release of reset SHALL be re-qualified as a new press after STABLE_MS ticks.
REQ-030 The first tick after reset SHALL occur TICK_DIV cycles after iRST deasserts.

Structure
REQ-031 The FSM state encoding and the default timing constants SHALL live in shared package button_pkg.
REQ-032 The prescaler SHALL be sub-module tick_gen, with parameter DIV, ports iCLK and iRST, and output oTICK; tick_gen is reusable by the LED blink logic.
REQ-033 Counter widths SHALL be derived from the parameters via $clog2.

Verification
REQ-034 The bench SHALL use TICK_DIV=12, STABLE_MS=5, LONG_MS=20, half period 41.67 ns, and hold iRST high for 3 cycles.
REQ-035 Clean press of iBTN=1 for 10 ticks SHALL produce one oPRESS about 5 ticks plus 2 cycles after the edge, oBTN=1, and oCNT=1.
REQ-036 Bounce of iBTN toggling every 1.5 ticks for 4 ticks, then settling high, SHALL produce exactly one oPRESS and no oRELEASE.
REQ-037 A glitch of iBTN=1 held for 3 ticks SHALL produce no pulses, with oBTN=0 and oCNT=0.
REQ-038 Holding the button for 30 ticks SHALL produce exactly one oLONG, 20 ticks after oPRESS; release then SHALL give oRELEASE 5 ticks later.
REQ-039 256 clean presses SHALL wrap oCNT to 0; asserting iRST mid-PRESSED SHALL drop oBTN to 0 on the next edge, with no oRELEASE.
